// File: rtl/video_timing_pkg.sv
// ============================================================================
// Module      : video_timing_pkg
// Description : Raster timing helpers shared by video_timing_gen and its axis
//               counters (totals, sync window bounds, sync pin polarity).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package video_timing_pkg;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int sync_start(input int active, input int fp);
        return active + fp;
    endfunction

    function automatic int sync_end(input int active, input int fp, input int sync);
        return active + fp + sync;
    endfunction

    function automatic logic sync_level(input logic asserted, input logic pol);
        return asserted ? pol : ~pol;
    endfunction

endpackage

`default_nettype wire

// File: rtl/video_axis_counter.sv
// ============================================================================
// Module      : video_axis_counter
// Description : One raster axis: enabled counter wrapping at TOTAL (or TOTAL+1
//               when extend is set), registered blank and sync decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module video_axis_counter
    import video_timing_pkg::*;
#(
    parameter int W          = 11,
    parameter int TOTAL      = 632,
    parameter int ACTIVE     = 512,
    parameter int SYNC_START = 520,
    parameter int SYNC_END   = 567,
    parameter bit SYNC_POL   = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         extend,
    output logic [W-1:0] pos,
    output logic         blank,
    output logic         sync,
    output logic         blank_nxt,
    output logic         at_end
);

    localparam logic [W-1:0] c_last       = W'(TOTAL - 1);
    localparam logic [W-1:0] c_active     = W'(ACTIVE);
    localparam logic [W-1:0] c_sync_start = W'(SYNC_START);
    localparam logic [W-1:0] c_sync_end   = W'(SYNC_END);

    logic [W-1:0] w_last;
    logic [W-1:0] w_pos_nxt;
    logic         w_sync_nxt;

    assign w_last = extend ? c_last + W'(1) : c_last;
    assign at_end = (pos == w_last);

    always_comb begin
        w_pos_nxt = pos;
        if (en) begin
            w_pos_nxt = at_end ? '0 : pos + W'(1);
        end
    end

    // Decode the next count so the flags land on the same edge as the counter.
    assign blank_nxt  = (w_pos_nxt >= c_active);
    assign w_sync_nxt = sync_level((w_pos_nxt >= c_sync_start) && (w_pos_nxt < c_sync_end), SYNC_POL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos   <= '0;
            blank <= 1'b0;
            sync  <= ~SYNC_POL;
        end else begin
            pos   <= w_pos_nxt;
            blank <= blank_nxt;
            sync  <= w_sync_nxt;
        end
    end

endmodule

`default_nettype wire

// File: rtl/video_timing_gen.sv
// ============================================================================
// Module      : video_timing_gen
// Description : Parametrised raster timing generator (H/V counters, sync,
//               blank, data enable, line/frame markers). Optional interlace via
//               VIDEO_TIMING_INTERLACE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE  = 512,
    parameter int H_FP      = 8,
    parameter int H_SYNC    = 47,
    parameter int H_BP      = 65,
    parameter int V_ACTIVE  = 240,
    parameter int V_FP      = 1,
    parameter int V_SYNC    = 3,
    parameter int V_BP      = 18,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int HW        = 11,
    parameter int VW        = 10
) (
    input  logic          clk_vid,
    input  logic          reset_n,
    input  logic          ce_pix,
    output logic [HW-1:0] hpos,
    output logic [VW-1:0] vpos,
    output logic          hsync,
    output logic          vsync,
    output logic          hblank,
    output logic          vblank,
    output logic          de,
    output logic          line_start,
    output logic          frame_start,
    output logic          field
);

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    logic w_h_end;
    logic w_v_end;
    logic w_h_blank_nxt;
    logic w_v_blank_nxt;
    logic w_line_wrap;
    logic w_frame_wrap;
    logic w_extend;

    assign w_line_wrap  = ce_pix & w_h_end;
    assign w_frame_wrap = w_line_wrap & w_v_end;

    video_axis_counter #(
        .W          (HW),
        .TOTAL      (H_TOTAL),
        .ACTIVE     (H_ACTIVE),
        .SYNC_START (sync_start(H_ACTIVE, H_FP)),
        .SYNC_END   (sync_end(H_ACTIVE, H_FP, H_SYNC)),
        .SYNC_POL   (HSYNC_POL)
    ) u_h_axis (
        .clk       (clk_vid),
        .rst_n     (reset_n),
        .en        (ce_pix),
        .extend    (1'b0),
        .pos       (hpos),
        .blank     (hblank),
        .sync      (hsync),
        .blank_nxt (w_h_blank_nxt),
        .at_end    (w_h_end)
    );

    video_axis_counter #(
        .W          (VW),
        .TOTAL      (V_TOTAL),
        .ACTIVE     (V_ACTIVE),
        .SYNC_START (sync_start(V_ACTIVE, V_FP)),
        .SYNC_END   (sync_end(V_ACTIVE, V_FP, V_SYNC)),
        .SYNC_POL   (VSYNC_POL)
    ) u_v_axis (
        .clk       (clk_vid),
        .rst_n     (reset_n),
        .en        (w_line_wrap),
        .extend    (w_extend),
        .pos       (vpos),
        .blank     (vblank),
        .sync      (vsync),
        .blank_nxt (w_v_blank_nxt),
        .at_end    (w_v_end)
    );

`ifdef VIDEO_TIMING_INTERLACE_EN
    // Odd fields carry one extra blanked line past the back porch.
    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            field <= 1'b0;
        end else if (w_frame_wrap) begin
            field <= ~field;
        end
    end
    assign w_extend = field;
`else
    assign field    = 1'b0;
    assign w_extend = 1'b0;
`endif

    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            de          <= 1'b1;
        end else begin
            line_start  <= w_line_wrap;
            frame_start <= w_frame_wrap;
            de          <= ~w_h_blank_nxt & ~w_v_blank_nxt;
        end
    end

endmodule

`default_nettype wire
